// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard inputs from ID/EX and stage hold/flush controls.
// slave  = the controller side (pipe_ctrl), master = the pipeline side.
interface pipe_ctrl_if;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_rd_en;
    logic        id_rs2_rd_en;
    logic [4:0]  ex_addr_rd;
    logic        ex_reg_wr_en;
    logic [2:0]  ex_load_code;
    logic        jmp_taken;
    logic        mem_busy;
    logic        hold_n_pc;
    logic        hold_n_if_id;
    logic        hold_n_id_ex;
    logic        hold_n_ex_mem;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] stall_cnt;

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_rd_en, id_rs2_rd_en,
        input  ex_addr_rd, ex_reg_wr_en, ex_load_code, jmp_taken, mem_busy,
        output hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem,
        output flush_if_id, flush_id_ex, stall_cnt
    );

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_rd_en, id_rs2_rd_en,
        output ex_addr_rd, ex_reg_wr_en, ex_load_code, jmp_taken, mem_busy,
        input  hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem,
        input  flush_if_id, flush_id_ex, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, jump flushes, memory freeze.
// Optional stalled-cycle counter enabled by macro PIPE_CTRL_PERF_CNT_EN.
`ifndef LOAD_NOPE
`define LOAD_NOPE 3'b000
`endif

module pipe_ctrl (
    input logic        clk,
    input logic        rst_n,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_e;

    state_e state_q, state_d;
    logic   jmp_pend_q, jmp_pend_d;
    logic   lu_hazard;
    logic   hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem;
    logic   flush_if_id, flush_id_ex;

    // Load-use hazard: EX load writing a non-zero rd that ID is about to read.
    always_comb begin
        lu_hazard = (bus.ex_load_code != `LOAD_NOPE) && bus.ex_reg_wr_en &&
                    (bus.ex_addr_rd != 5'd0) &&
                    ((bus.id_rs1_rd_en && (bus.id_rs1_addr == bus.ex_addr_rd)) ||
                     (bus.id_rs2_rd_en && (bus.id_rs2_addr == bus.ex_addr_rd)));
    end

    // State and pending-jump registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            jmp_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            jmp_pend_q <= jmp_pend_d;
        end
    end

    // Next-state and zero-latency hold/flush outputs; priority busy > jump > load-use.
    always_comb begin
        state_d       = state_q;
        jmp_pend_d    = jmp_pend_q;
        hold_n_pc     = 1'b1;
        hold_n_if_id  = 1'b1;
        hold_n_id_ex  = 1'b1;
        hold_n_ex_mem = 1'b1;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        case (state_q)
            StRun: begin
                if (bus.mem_busy) begin
                    {hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem} = 4'b0000;
                    if (bus.jmp_taken) jmp_pend_d = 1'b1;
                    state_d = StMemWait;
                end else if (bus.jmp_taken) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    state_d     = StFlush;
                end else if (lu_hazard) begin
                    hold_n_pc    = 1'b0;
                    hold_n_if_id = 1'b0;
                    flush_id_ex  = 1'b1;
                end
            end
            StFlush: begin
                // Extra cycle to squash the instruction already in synchronous fetch.
                if (bus.mem_busy) begin
                    {hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem} = 4'b0000;
                    jmp_pend_d = 1'b1;
                    state_d    = StMemWait;
                end else begin
                    flush_if_id = 1'b1;
                    state_d     = StRun;
                end
            end
            StMemWait: begin
                if (bus.mem_busy) begin
                    {hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem} = 4'b0000;
                    if (bus.jmp_taken) jmp_pend_d = 1'b1;
                end else if (jmp_pend_q || bus.jmp_taken) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    jmp_pend_d  = 1'b0;
                    state_d     = StFlush;
                end else begin
                    if (lu_hazard) begin
                        hold_n_pc    = 1'b0;
                        hold_n_if_id = 1'b0;
                        flush_id_ex  = 1'b1;
                    end
                    state_d = StRun;
                end
            end
            default: begin
                state_d    = StRun;
                jmp_pend_d = 1'b0;
            end
        endcase
    end

    // Drive the interface outputs.
    always_comb begin
        bus.hold_n_pc     = hold_n_pc;
        bus.hold_n_if_id  = hold_n_if_id;
        bus.hold_n_id_ex  = hold_n_id_ex;
        bus.hold_n_ex_mem = hold_n_ex_mem;
        bus.flush_if_id   = flush_if_id;
        bus.flush_id_ex   = flush_id_ex;
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles where the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'h0000_0000;
        end else if (!hold_n_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table plus reset/counter sequences.
`ifndef LOAD_NOPE
`define LOAD_NOPE 3'b000
`endif

module tb_pipe_ctrl;
    localparam logic [2:0] Ld = 3'b010;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipe_ctrl_if bus ();

    pipe_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1;
        logic       rs1_en;
        logic [4:0] rs2;
        logic       rs2_en;
        logic [4:0] rd;
        logic       wr_en;
        logic [2:0] ld;
        logic       jmp;
        logic       busy;
        logic [3:0] hold;   // {pc, if_id, id_ex, ex_mem}
        logic [1:0] flush;  // {if_id, id_ex}
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic [4:0] rs1, input logic rs1_en,
                                input logic [4:0] rs2, input logic rs2_en,
                                input logic [4:0] rd, input logic wr_en,
                                input logic [2:0] ld, input logic jmp, input logic busy,
                                input logic [3:0] hold, input logic [1:0] flush);
        vec_t v;
        v.rs1 = rs1; v.rs1_en = rs1_en; v.rs2 = rs2; v.rs2_en = rs2_en;
        v.rd = rd; v.wr_en = wr_en; v.ld = ld; v.jmp = jmp; v.busy = busy;
        v.hold = hold; v.flush = flush;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.id_rs1_addr  = v.rs1;
        bus.id_rs1_rd_en = v.rs1_en;
        bus.id_rs2_addr  = v.rs2;
        bus.id_rs2_rd_en = v.rs2_en;
        bus.ex_addr_rd   = v.rd;
        bus.ex_reg_wr_en = v.wr_en;
        bus.ex_load_code = v.ld;
        bus.jmp_taken    = v.jmp;
        bus.mem_busy     = v.busy;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] holds();
        return {bus.hold_n_pc, bus.hold_n_if_id, bus.hold_n_id_ex, bus.hold_n_ex_mem};
    endfunction

    function automatic logic [1:0] flushes();
        return {bus.flush_if_id, bus.flush_id_ex};
    endfunction

    task automatic chk_out(input string name, input logic [3:0] h, input logic [1:0] f);
        chk({name, "_hold"}, {28'd0, holds()}, {28'd0, h});
        chk({name, "_flush"}, {30'd0, flushes()}, {30'd0, f});
        // A stage register is never both held and flushed.
        chk({name, "_excl"}, {31'd0, (~bus.hold_n_if_id & bus.flush_if_id) |
                                     (~bus.hold_n_id_ex & bus.flush_id_ex)}, 32'd0);
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        #1;
        chk_out(name, v.hold, v.flush);
    endtask

    initial begin
        vec_t idle;
        vec_t lu;
        logic [31:0] exp_cnt;
        checks   = 0;
        failures = 0;

        //             rs1  e  rs2  e  rd   w  ld          j  b  hold     flush
        idle = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 0, 4'b1111, 2'b00);
        lu   = mk(5'd0, 0, 5'd5, 1, 5'd5, 1, Ld,         0, 0, 4'b0011, 2'b01);

        tbl[0]  = idle;
        tbl[1]  = lu;
        tbl[2]  = idle;
        tbl[3]  = mk(5'd0, 0, 5'd0, 1, 5'd0, 1, Ld,         0, 0, 4'b1111, 2'b00);
        tbl[4]  = mk(5'd7, 0, 5'd0, 0, 5'd7, 1, Ld,         0, 0, 4'b1111, 2'b00);
        tbl[5]  = mk(5'd7, 1, 5'd0, 0, 5'd7, 1, Ld,         0, 0, 4'b0011, 2'b01);
        tbl[6]  = mk(5'd7, 1, 5'd7, 1, 5'd7, 1, `LOAD_NOPE, 0, 0, 4'b1111, 2'b00);
        tbl[7]  = mk(5'd7, 1, 5'd7, 1, 5'd7, 0, Ld,         0, 0, 4'b1111, 2'b00);
        tbl[8]  = mk(5'd0, 0, 5'd5, 1, 5'd5, 1, Ld,         1, 0, 4'b1111, 2'b11);
        tbl[9]  = mk(5'd0, 0, 5'd5, 1, 5'd5, 1, Ld,         0, 0, 4'b1111, 2'b10);
        tbl[10] = idle;
        tbl[11] = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 1, 1, 4'b0000, 2'b00);
        tbl[12] = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 1, 4'b0000, 2'b00);
        tbl[13] = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 1, 4'b0000, 2'b00);
        tbl[14] = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 0, 4'b1111, 2'b11);
        tbl[15] = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 0, 4'b1111, 2'b10);
        tbl[16] = idle;
        tbl[17] = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 1, 4'b0000, 2'b00);
        tbl[18] = lu;
        tbl[19] = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 1, 0, 4'b1111, 2'b11);
        tbl[20] = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 1, 4'b0000, 2'b00);
        tbl[21] = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 0, 4'b1111, 2'b11);
        tbl[22] = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 0, 4'b1111, 2'b10);
        tbl[23] = idle;
        tbl[24] = mk(5'd0, 0, 5'd5, 1, 5'd5, 1, Ld,         0, 1, 4'b0000, 2'b00);
        tbl[25] = idle;

        // Reset state.
        rst_n = 1'b0;
        drive(idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_out("reset", 4'b1111, 2'b00);
        chk("reset_cnt", bus.stall_cnt, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Nine PC-hold cycles in the table.
`ifdef PIPE_CTRL_PERF_CNT_EN
        exp_cnt = 32'd9;
`else
        exp_cnt = 32'd0;
`endif
        @(negedge clk);
        drive(idle);
        #1;
        chk("table_cnt", bus.stall_cnt, exp_cnt);

        // Reset mid-stall with a jump pending: no flush may follow release.
        step(mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 1, 1, 4'b0000, 2'b00), "rst_busy0");
        step(mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 1, 4'b0000, 2'b00), "rst_busy1");
        step(mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 1, 4'b0000, 2'b00), "rst_busy2");
        @(negedge clk);
        rst_n = 1'b0;
        drive(idle);
        #1;
        chk_out("rst_mid", 4'b1111, 2'b00);
        chk("rst_mid_cnt", bus.stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(idle, "rst_rel0");
        step(idle, "rst_rel1");

        // Counter: two load-use stalls and three busy cycles.
        step(lu, "cnt_lu0");
        step(idle, "cnt_gap");
        step(lu, "cnt_lu1");
        step(mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 1, 4'b0000, 2'b00), "cnt_b0");
        step(mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 1, 4'b0000, 2'b00), "cnt_b1");
        step(mk(5'd0, 0, 5'd0, 0, 5'd0, 0, `LOAD_NOPE, 0, 1, 4'b0000, 2'b00), "cnt_b2");
        step(idle, "cnt_rel");
`ifdef PIPE_CTRL_PERF_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        chk("stall_cnt", bus.stall_cnt, exp_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
